// File: rtl/counter_monitor_pkg.sv
// Shared FSM state encoding and lock threshold for counter_monitor.
package counter_monitor_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSync  = 2'd1,
    StTrack = 2'd2,
    StErr   = 2'd3
  } state_e;

  // Consecutive +1 steps needed in SYNC before declaring lock.
  localparam logic [1:0] LockThreshold = 2'd2;

endpackage

// File: rtl/counter_monitor_if.sv
// Monitor-side bus for counter_monitor; err_cnt exists only with COUNTER_MONITOR_ERRCNT_EN.
interface counter_monitor_if #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned WRAP_W = 8
);
  logic [WIDTH-1:0]  q_in;
  logic              clr;
  logic              locked;
  logic              err;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_cnt;
`ifdef COUNTER_MONITOR_ERRCNT_EN
  logic [WRAP_W-1:0] err_cnt;

  modport master (output q_in, clr, input locked, err, wrap_pulse, wrap_cnt, err_cnt);
  modport slave  (input q_in, clr, output locked, err, wrap_pulse, wrap_cnt, err_cnt);
`else
  modport master (output q_in, clr, input locked, err, wrap_pulse, wrap_cnt);
  modport slave  (input q_in, clr, output locked, err, wrap_pulse, wrap_cnt);
`endif
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and synchronous active-low reset.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_monitor.sv
// Tracks an upstream +1 counter: lock, sticky error, wrap pulse and saturating statistics.
// Optional err_cnt statistics counter is built when COUNTER_MONITOR_ERRCNT_EN is defined.
module counter_monitor
  import counter_monitor_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned WRAP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  counter_monitor_if.slave mon
);

  localparam logic [WIDTH-1:0] MaxVal = '1;

  state_e            state_q;
  logic [WIDTH-1:0]  prev_q;
  logic [1:0]        good_q;
  logic              locked_q;
  logic              err_q;
  logic              wrap_pulse_q;
  logic [WIDTH-1:0]  q;
  logic [WIDTH-1:0]  prev_inc;
  logic              step;
  logic              wrap_ev;
  logic              err_ev;
  logic [WRAP_W-1:0] wrap_cnt;

  assign q        = mon.q_in;
  assign prev_inc = prev_q + WIDTH'(1);
  assign step     = (q == prev_inc);
  assign wrap_ev  = (state_q == StTrack) && step && (prev_q == MaxVal);
  // Non-step zero is always an upstream restart (max->0 would have been a step).
  assign err_ev   = (state_q == StTrack) && !step && (q != prev_q) && (q != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      prev_q       <= '0;
      good_q       <= '0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      prev_q       <= q;
      wrap_pulse_q <= wrap_ev;
      err_q        <= mon.clr ? 1'b0 : (err_q | err_ev);
      unique case (state_q)
        StIdle: begin
          state_q  <= StSync;
          good_q   <= '0;
          locked_q <= 1'b0;
        end
        StSync: begin
          if (!step) begin
            good_q <= '0;
          end else if (good_q + 2'd1 == LockThreshold) begin
            state_q  <= StTrack;
            good_q   <= '0;
            locked_q <= 1'b1;
          end else begin
            good_q <= good_q + 2'd1;
          end
        end
        StTrack: begin
          if (!step) begin
            state_q  <= err_ev ? StErr : StSync;
            good_q   <= '0;
            locked_q <= 1'b0;
          end
        end
        StErr: begin
          state_q  <= StSync;
          good_q   <= '0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH(WRAP_W)
  ) u_wrap_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (wrap_ev),
    .clr  (mon.clr),
    .count(wrap_cnt)
  );

`ifdef COUNTER_MONITOR_ERRCNT_EN
  logic [WRAP_W-1:0] err_cnt;

  sat_counter #(
    .WIDTH(WRAP_W)
  ) u_err_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (err_ev),
    .clr  (mon.clr),
    .count(err_cnt)
  );

  assign mon.err_cnt = err_cnt;
`endif

  assign mon.locked     = locked_q;
  assign mon.err        = err_q;
  assign mon.wrap_pulse = wrap_pulse_q;
  assign mon.wrap_cnt   = wrap_cnt;

endmodule

// File: tb/tb_counter_monitor.sv
// Self-checking bench: directed scenarios plus random stimulus against a behavioural model.
module tb_counter_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] q_in = 4'd0;
  logic       clr = 1'b0;
  logic [3:0] cq = 4'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_monitor_if #(.WIDTH(4), .WRAP_W(8)) if8 ();
  counter_monitor_if #(.WIDTH(4), .WRAP_W(2)) if2 ();

  assign if8.q_in = q_in;
  assign if8.clr  = clr;
  assign if2.q_in = q_in;
  assign if2.clr  = clr;

  counter_monitor #(.WIDTH(4), .WRAP_W(8)) u_dut8 (.clk(clk), .reset(rst), .mon(if8.slave));
  counter_monitor #(.WIDTH(4), .WRAP_W(2)) u_dut2 (.clk(clk), .reset(rst), .mon(if2.slave));

  // Behavioural model: lock after two consecutive +1 steps, etc.
  int m_prev = 0, m_run = 0, w8 = 0, w2 = 0;
  bit m_fresh = 1, m_after_err = 0, m_locked = 0, m_err = 0, m_pulse = 0;
  bit started = 0, stp, wrap_e, err_e;
`ifdef COUNTER_MONITOR_ERRCNT_EN
  int e8 = 0, e2 = 0;
`endif

  function automatic int sat_inc(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    started = 1;
    if (!rst) begin
      m_prev = 0; m_run = 0; w8 = 0; w2 = 0;
      m_fresh = 1; m_after_err = 0; m_locked = 0; m_err = 0; m_pulse = 0;
`ifdef COUNTER_MONITOR_ERRCNT_EN
      e8 = 0; e2 = 0;
`endif
    end else begin
      stp = (int'(q_in) == (m_prev + 1) % 16);
      wrap_e = 0;
      err_e = 0;
      if (m_fresh) begin
        m_fresh = 0;
        m_run = 0;
      end else if (m_after_err) begin
        m_after_err = 0;
        m_run = 0;
      end else if (!m_locked) begin
        m_run = stp ? m_run + 1 : 0;
        if (m_run == 2) begin
          m_locked = 1;
          m_run = 0;
        end
      end else if (stp) begin
        wrap_e = (m_prev == 15);
      end else begin
        m_locked = 0;
        m_run = 0;
        if (int'(q_in) != m_prev && q_in != 4'd0) begin
          err_e = 1;
          m_after_err = 1;
        end
      end
      m_prev = int'(q_in);
      m_pulse = wrap_e;
      if (clr) begin
        m_err = 0; w8 = 0; w2 = 0;
`ifdef COUNTER_MONITOR_ERRCNT_EN
        e8 = 0; e2 = 0;
`endif
      end else begin
        m_err = m_err | err_e;
        if (wrap_e) begin
          w8 = sat_inc(w8, 255);
          w2 = sat_inc(w2, 3);
        end
`ifdef COUNTER_MONITOR_ERRCNT_EN
        if (err_e) begin
          e8 = sat_inc(e8, 255);
          e2 = sat_inc(e2, 3);
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("locked8", int'(if8.locked), int'(m_locked));
      chk("err8", int'(if8.err), int'(m_err));
      chk("pulse8", int'(if8.wrap_pulse), int'(m_pulse));
      chk("wrap_cnt8", int'(if8.wrap_cnt), w8);
      chk("locked2", int'(if2.locked), int'(m_locked));
      chk("err2", int'(if2.err), int'(m_err));
      chk("pulse2", int'(if2.wrap_pulse), int'(m_pulse));
      chk("wrap_cnt2", int'(if2.wrap_cnt), w2);
`ifdef COUNTER_MONITOR_ERRCNT_EN
      chk("err_cnt8", int'(if8.err_cnt), e8);
      chk("err_cnt2", int'(if2.err_cnt), e2);
`endif
    end
  end

  // Apply inputs, clock once, return with registered outputs settled.
  task automatic tick(input logic [3:0] q, input logic c, input logic r);
    q_in = q;
    clr = c;
    rst = r;
    cq = q;
    @(posedge clk);
    #3;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(cq + 4'd1, 1'b0, 1'b1);
  endtask

  int pr;
  logic [3:0] nq;

  initial begin
    tick(4'd0, 1'b0, 1'b0);
    tick(4'd0, 1'b0, 1'b0);
    chk("rst_locked", int'(if8.locked), 0);
    chk("rst_wrap_cnt", int'(if8.wrap_cnt), 0);

    // Lock-up on 0,1,2,3
    tick(4'd0, 1'b0, 1'b1);
    tick(4'd1, 1'b0, 1'b1);
    chk("pre_lock", int'(if8.locked), 0);
    tick(4'd2, 1'b0, 1'b1);
    chk("lock_rise", int'(if8.locked), 1);
    chk("model_lock", int'(m_locked), 1);
    chk("lock_err", int'(if8.err), 0);
    tick(4'd3, 1'b0, 1'b1);

    // Wrap 15 -> 0
    run(12);
    chk("pre_wrap_pulse", int'(if8.wrap_pulse), 0);
    run(1);
    chk("wrap_pulse", int'(if8.wrap_pulse), 1);
    chk("wrap_cnt_1", int'(if8.wrap_cnt), 1);
    chk("model_wrap", w8, 1);
    run(1);
    chk("wrap_pulse_end", int'(if8.wrap_pulse), 0);
    run(31);
    chk("wrap_cnt_3", int'(if8.wrap_cnt), 3);

    // Sequence error 5 -> 9, then resync on A,B,C
    run(5);
    tick(4'd9, 1'b0, 1'b1);
    chk("err_set", int'(if8.err), 1);
    chk("err_unlock", int'(if8.locked), 0);
`ifdef COUNTER_MONITOR_ERRCNT_EN
    chk("err_cnt_1", int'(if8.err_cnt), 1);
`endif
    tick(4'hA, 1'b0, 1'b1);
    tick(4'hB, 1'b0, 1'b1);
    tick(4'hC, 1'b0, 1'b1);
    chk("relock", int'(if8.locked), 1);
    chk("err_sticky", int'(if8.err), 1);

    // Clear keeps lock
    tick(4'hD, 1'b1, 1'b1);
    chk("clr_err", int'(if8.err), 0);
    chk("clr_wrap", int'(if8.wrap_cnt), 0);
    chk("clr_lock", int'(if8.locked), 1);

    // Upstream restart at 7
    run(10);
    tick(4'd0, 1'b0, 1'b1);
    chk("restart_unlock", int'(if8.locked), 0);
    chk("restart_no_err", int'(if8.err), 0);
    tick(4'd0, 1'b0, 1'b1);
    tick(4'd0, 1'b0, 1'b1);
    run(2);
    chk("restart_relock", int'(if8.locked), 1);

    // Saturation of the 2-bit instance, then clr on a wrap cycle
    run(80);
    chk("sat_wrap2", int'(if2.wrap_cnt), 3);
    chk("wrap8_6", int'(if8.wrap_cnt), 6);
    run(13);
    tick(4'd0, 1'b1, 1'b1);
    chk("clr_wrap_pulse", int'(if2.wrap_pulse), 1);
    chk("clr_wrap_win", int'(if2.wrap_cnt), 0);

    // Reset mid-TRACK
    run(3);
    tick(cq + 4'd1, 1'b1, 1'b0);
    chk("midrst_locked", int'(if8.locked), 0);
    chk("midrst_pulse", int'(if8.wrap_pulse), 0);
    chk("midrst_wrap", int'(if8.wrap_cnt), 0);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      pr = int'($urandom_range(0, 99));
      if (pr < 80) nq = cq + 4'd1;
      else if (pr < 88) nq = cq;
      else if (pr < 93) nq = 4'd0;
      else nq = 4'($urandom_range(0, 15));
      tick(nq, ($urandom_range(0, 49) == 0), ($urandom_range(0, 299) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
